// File: rtl/mult_pkg.sv
// Shared state encoding for the shift-add multiplier stages.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/add_unit.sv
// WIDTH-bit adder with carry out: {cout, sum} = a + b.
// Purely combinational, no flow control.
module add_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/shift_add_controller.sv
// Sequential shift-add multiplier controller driving an external multiplier shift register.
// DONE is entered 2*WIDTH+1 edges after start is accepted; start is ignored while busy.
import mult_pkg::*;

module shift_add_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic             ops,
    output logic             lds,
    output logic             ebl,
    output logic             sis,
    output logic [WIDTH-1:0] prod_hi,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] m_reg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum;
    logic             cout;

    add_unit #(.WIDTH(WIDTH)) u_add (
        .a    (acc),
        .b    (m_reg),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = ADD;
            ADD:     state_nxt = SHIFT;
            SHIFT:   state_nxt = (cnt == CW'(1)) ? DONE : ADD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The carry from the add is shifted into the accumulator MSB, so it is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            m_reg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg <= mcand;
                        acc   <= '0;
                        carry <= 1'b0;
                        cnt   <= CW'(WIDTH);
                    end
                end
                ADD: begin
                    if (ops) begin
                        acc   <= sum;
                        carry <= cout;
                    end
                end
                SHIFT: begin
                    acc   <= {carry, acc[WIDTH-1:1]};
                    carry <= 1'b0;
                    cnt   <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign lds     = (state == LOAD);
    assign ebl     = (state == LOAD) || (state == SHIFT);
    assign sis     = acc[0];
    assign prod_hi = acc;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_shift_add_controller.sv
// Directed bench: controller plus a model of the downstream multiplier shift register.
module tb_shift_add_controller;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] mcand = '0;
    logic             ops;
    logic             lds;
    logic             ebl;
    logic             sis;
    logic [WIDTH-1:0] prod_hi;
    logic             busy;
    logic             done;

    logic [WIDTH-1:0] mult_op = '0;
    logic [WIDTH-1:0] sreg = '0;
    int               checks = 0;
    int               errors = 0;

    shift_add_controller #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .ops     (ops),
        .lds     (lds),
        .ebl     (ebl),
        .sis     (sis),
        .prod_hi (prod_hi),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lds && ebl)
            sreg <= mult_op;
        else if (ebl && !lds)
            sreg <= {sis, sreg[WIDTH-1:1]};
    end
    assign ops = sreg[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ctrl"}, {27'b0, lds, ebl, sis, busy, done}, 32'h0);
        check({tag, " prod_hi"}, {24'b0, prod_hi}, 32'h0);
    endtask

    // restart_edge: pulse start again before that edge; rst_edge: assert reset just after that edge;
    // hold: keep start high through the whole operation.
    task automatic run_op(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                          input int restart_edge, input int rst_edge, input bit hold,
                          input logic [15:0] exp_prod);
        int          first_done = 0;
        int          ndone = 0;
        int          ebl_bad = 0;
        logic [15:0] prod = '0;
        bit          seen = 0;
        @(negedge clk);
        start = 1'b1;
        mcand = mc;
        mult_op = mp;
        @(posedge clk);
        #1;
        check({tag, " load lds/ebl"}, {30'b0, lds, ebl}, 32'h3);
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            mcand = ~mc;
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == rst_edge) begin
                #1 rst = 1'b1;
                #1;
                check_idle_outputs({tag, " async reset"});
                break;
            end
            if (done) begin
                ndone++;
                if (first_done == 0) begin
                    first_done = k;
                    prod = {prod_hi, sreg};
                end
            end
            if (k <= 16 && ebl !== (k % 2 == 0)) ebl_bad++;
            if (k == 17) check({tag, " busy in done"}, {31'b0, busy}, 32'h1);
            if (k == 18) check({tag, " busy after done"}, {31'b0, busy}, 32'h0);
            if (hold && k == 19) check({tag, " auto restart lds"}, {31'b0, lds}, 32'h1);
            if (k + 1 == restart_edge) begin
                @(negedge clk);
                start = 1'b1;
                mcand = 8'h55;
            end else if (k == restart_edge) begin
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (rst_edge != 0) begin
            check({tag, " no done before reset"}, ndone, 0);
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            ndone = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                if (done) ndone++;
            end
            check({tag, " no done after reset"}, ndone, 0);
            check({tag, " idle after reset"}, {31'b0, busy}, 32'h0);
        end else begin
            check({tag, " ebl pattern errors"}, ebl_bad, 0);
            check({tag, " done edge"}, first_done, 17);
            check({tag, " done count"}, ndone, 1);
            check({tag, " product"}, {16'b0, prod}, {16'b0, exp_prod});
            if (hold) begin
                @(negedge clk);
                start = 1'b0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(posedge clk);
                    #1;
                    if (done) begin
                        seen = 1;
                        prod = {prod_hi, sreg};
                    end
                end
                check({tag, " second done seen"}, {31'b0, seen}, 32'h1);
                check({tag, " second product"}, {16'b0, prod}, {16'b0, exp_prod});
            end
        end
    endtask

    initial begin
        #12;
        check_idle_outputs("reset state");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle after release");

        run_op("0x0D*0x0B", 8'h0D, 8'h0B, 0, 0, 1'b0, 16'h008F);
        run_op("0xFF*0xFF", 8'hFF, 8'hFF, 0, 0, 1'b0, 16'hFE01);
        run_op("0x00*0xA5", 8'h00, 8'hA5, 0, 0, 1'b0, 16'h0000);
        run_op("restart ignored", 8'h9C, 8'h37, 5, 0, 1'b0, 16'h2184);
        run_op("reset mid-op", 8'h0D, 8'h0B, 0, 9, 1'b0, 16'h0000);
        run_op("0x03*0x05", 8'h03, 8'h05, 0, 0, 1'b0, 16'h000F);
        run_op("start held", 8'h12, 8'h34, 0, 0, 1'b1, 16'h03A8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_add_controller.md
SHIFT_ADD_CONTROLLER -- requirements
Module: shift_add_controller

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits; multiplier register width and accumulator width.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 SHALL have port: mcand  input  WIDTH  multiplicand; captured on the edge that accepts start.
REQ-006 SHALL have port: ops  input  1  serial output (LSB) of the downstream multiplier shift register.
REQ-007 SHALL have port: lds  output  1  parallel-load select to the multiplier shift register.
REQ-008 SHALL have port: ebl  output  1  enable to the multiplier shift register (0 = hold).
REQ-009 SHALL have port: sis  output  1  serial input to the multiplier shift register; equals accumulator bit 0.
REQ-010 SHALL have port: prod_hi  output  WIDTH  accumulator, i.e. the upper product half.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: done  output  1  single-cycle completion pulse.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, ADD, SHIFT, DONE; all outputs are decoded from registered state only.
REQ-014 IDLE: lds=0, ebl=0; start=1 -> LOAD, capturing mcand into M, clearing accumulator A, carry C, and loading counter with WIDTH.
REQ-015 LOAD: lds=1, ebl=1 for exactly one cycle (downstream register loads its operand); -> ADD.
REQ-016 ADD: lds=0, ebl=0; if ops=1 then {C,A} <= A + M (WIDTH+1-bit sum), else A, C unchanged; -> SHIFT.
REQ-017 SHIFT: lds=0, ebl=1, sis=A[0]; {C,A} <= {1'b0, C, A[WIDTH-1:1]}; counter decrements; counter reaching 0 -> DONE, else -> ADD.
REQ-018 DONE: done=1, busy=1, lds=0, ebl=0 for one cycle; -> IDLE; A holds final upper half until next accepted start.
REQ-019 Latency: DONE entered on the (2*WIDTH+1)th rising edge after the edge that accepted start (17 for WIDTH=8).
REQ-020 Final product SHALL be {prod_hi, downstream register contents}; carry out of any add is never lost (absorbed by next shift).
REQ-021 start asserted in LOAD/ADD/SHIFT/DONE SHALL be ignored; no queuing; mcand changes while busy SHALL have no effect.
REQ-022 start held high continuously SHALL restart one cycle after DONE (IDLE visited for one cycle).
REQ-023 Counter SHALL be $clog2(WIDTH+1) bits; no wrap: it is reloaded only in IDLE on accepted start.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, A=0, C=0, M=0, counter=0, lds=0, ebl=0, busy=0, done=0, sis=0.
REQ-025 Reset mid-operation SHALL abandon the operation with no done pulse; next start after release begins a fresh operation.

Structure
REQ-026 FSM state encoding and the state type SHALL live in shared package mult_pkg, reused by future multiplier stages.
REQ-027 The WIDTH+1-bit adder SHALL be a sub-module add_unit (a, b -> sum, cout); all other logic stays in shift_add_controller.

Verification
REQ-028 Bench SHALL connect lds/ebl/sis/ops to a WIDTH-bit shift register model (load on lds&ebl, shift right with sis in on ebl&!lds, hold on !ebl).
REQ-029 mcand=0x0D, multiplier=0x0B, start one cycle -> done at edge 17; prod_hi=0x00, low=0x8F (143).
REQ-030 mcand=0xFF, multiplier=0xFF -> prod_hi=0xFE, low=0x01 (65025); exercises carry on every add.
REQ-031 mcand=0x00, multiplier=0xA5 -> product 0x0000; ebl pattern still 0,1 alternating for 16 cycles.
REQ-032 start pulsed again at edge 5 of an operation with different mcand -> ignored; result of original operands; exactly one done.
REQ-033 rst asserted at edge 9 of an operation -> all outputs 0 asynchronously, no done; following start 0x03*0x05 -> product 0x000F.
